// File: rtl/mouse_cursor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mouse_cursor_ctrl_pkg
// Shared definitions for the PS/2 mouse cursor path and the display blocks
// that consume the cursor position.
//   - mouse_state_t : packet-assembly FSM encoding
//   - DEF_*         : default screen size and inter-byte timeout
//   - POS_W/CALC_W  : cursor coordinate width and signed arithmetic width
//   - ps2_delta()   : builds a 9-bit two's complement movement delta
// ---------------------------------------------------------------------------
package mouse_cursor_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    APPLY   = 2'd3
  } mouse_state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_TIMEOUT_CYC = 50000;  // 1 ms at 50 MHz

  localparam int POS_W   = 11;  // cursor coordinate width
  localparam int DELTA_W = 9;   // PS/2 movement: sign bit + 8-bit magnitude
  localparam int CALC_W  = 13;  // covers 0..2047 plus/minus 256 without overflow

  // The sign bit of each axis lives in byte0, the low eight bits in byte1/2.
  function automatic logic signed [DELTA_W-1:0] ps2_delta(input logic       sign_bit,
                                                          input logic [7:0] low_bits);
    return {sign_bit, low_bits};
  endfunction

endpackage

// File: rtl/mouse_cursor_ctrl_cursor_clamp.sv
// ---------------------------------------------------------------------------
// cursor_clamp
// Combinational: applies a signed movement delta to one cursor coordinate
// and clamps the result to [0, limit].
//   pos      : current coordinate
//   delta    : 9-bit two's complement movement
//   subtract : 1 -> pos - delta (Y axis, PS/2 up is screen down), 0 -> pos + delta
//   limit    : largest legal coordinate (screen size - 1)
//   clamped  : resulting coordinate
// ---------------------------------------------------------------------------
module cursor_clamp
  import mouse_cursor_ctrl_pkg::*;
(
  input  logic                      pos_dummy_unused_n,
  input  logic [POS_W-1:0]          pos,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                      subtract,
  input  logic [POS_W-1:0]          limit,
  output logic [POS_W-1:0]          clamped
);

  logic signed [CALC_W-1:0] pos_ext;
  logic signed [CALC_W-1:0] delta_ext;
  logic signed [CALC_W-1:0] limit_ext;
  logic signed [CALC_W-1:0] sum;
  logic                     unused_ok;

  always_comb begin
    pos_ext   = {{(CALC_W-POS_W){1'b0}}, pos};
    delta_ext = {{(CALC_W-DELTA_W){delta[DELTA_W-1]}}, delta};
    limit_ext = {{(CALC_W-POS_W){1'b0}}, limit};
    sum       = subtract ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
    clamped   = sum[POS_W-1:0];
    if (sum < 0) begin
      clamped = '0;
    end else if (sum > limit_ext) begin
      clamped = limit;
    end
  end

  assign unused_ok = pos_dummy_unused_n;

endmodule

// File: rtl/mouse_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// mouse_cursor_ctrl
// Assembles 3-byte PS/2 mouse packets and maintains a clamped on-screen
// cursor position plus button state.
//   CLOCK_50   : system clock, rising edge
//   reset      : synchronous, active-low
//   rx_byte    : byte from the PS/2 receiver, valid while rx_valid is high
//   rx_valid   : one-cycle strobe
//   cursor_x/y : registered cursor centre (column/row)
//   btn_left/right : current button levels
//   left_click : one-cycle pulse on a left-button press
//   pos_update : one-cycle pulse when the cursor position changes
//   pkt_error  : one-cycle pulse on a discarded byte or packet
// ---------------------------------------------------------------------------
module mouse_cursor_ctrl
  import mouse_cursor_ctrl_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic             btn_left,
  output logic             btn_right,
  output logic             left_click,
  output logic             pos_update,
  output logic             pkt_error
);

  localparam int               GAP_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC);
  localparam logic [POS_W-1:0] X_LIMIT = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_LIMIT = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] X_HOME  = POS_W'(H_ACTIVE / 2);
  localparam logic [POS_W-1:0] Y_HOME  = POS_W'(V_ACTIVE / 2);

  mouse_state_t     state_q, state_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [7:0]       byte2_q, byte2_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [POS_W-1:0] cursor_x_q, cursor_x_d;
  logic [POS_W-1:0] cursor_y_q, cursor_y_d;
  logic             btn_left_q, btn_left_d;
  logic             btn_right_q, btn_right_d;
  logic             left_click_q, left_click_d;
  logic             pos_update_q, pos_update_d;
  logic             pkt_error_q, pkt_error_d;

  logic signed [DELTA_W-1:0] dx, dy;
  logic [POS_W-1:0]          clamp_x, clamp_y;
  logic                      overflow;
  logic                      timeout;
  logic                      take_b0;

  assign dx       = ps2_delta(byte0_q[4], byte1_q);
  assign dy       = ps2_delta(byte0_q[5], byte2_q);
  assign overflow = byte0_q[6] | byte0_q[7];
  assign timeout  = (gap_q == GAP_MAX);

  cursor_clamp u_clamp_x (
    .pos_dummy_unused_n (1'b1),
    .pos                (cursor_x_q),
    .delta              (dx),
    .subtract           (1'b0),
    .limit              (X_LIMIT),
    .clamped            (clamp_x)
  );

  cursor_clamp u_clamp_y (
    .pos_dummy_unused_n (1'b1),
    .pos                (cursor_y_q),
    .delta              (dy),
    .subtract           (1'b1),
    .limit              (Y_LIMIT),
    .clamped            (clamp_y)
  );

  always_comb begin
    state_d      = state_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    byte2_d      = byte2_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    btn_left_d   = btn_left_q;
    btn_right_d  = btn_right_q;
    left_click_d = 1'b0;
    pos_update_d = 1'b0;
    pkt_error_d  = 1'b0;
    take_b0      = 1'b0;

    // Gap counter restarts on every byte and holds at the timeout value.
    if (rx_valid) begin
      gap_d = '0;
    end else if (timeout) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end

    case (state_q)
      WAIT_B0: begin
        take_b0 = rx_valid;
      end
      WAIT_B1: begin
        if (rx_valid) begin
          byte1_d = rx_byte;
          state_d = WAIT_B2;
        end else if (timeout) begin
          state_d     = WAIT_B0;
          pkt_error_d = 1'b1;
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          byte2_d = rx_byte;
          state_d = APPLY;
        end else if (timeout) begin
          state_d     = WAIT_B0;
          pkt_error_d = 1'b1;
        end
      end
      APPLY: begin
        state_d      = WAIT_B0;
        take_b0      = rx_valid;
        btn_left_d   = byte0_q[0];
        btn_right_d  = byte0_q[1];
        left_click_d = byte0_q[0] & ~btn_left_q;
        if (overflow) begin
          pkt_error_d = 1'b1;
        end else begin
          cursor_x_d   = clamp_x;
          cursor_y_d   = clamp_y;
          pos_update_d = (clamp_x != cursor_x_q) || (clamp_y != cursor_y_q);
        end
      end
      default: state_d = WAIT_B0;
    endcase

    // A first byte must carry the always-one bit 3; anything else is
    // dropped so the stream can re-align on a later byte.
    if (take_b0) begin
      if (rx_byte[3]) begin
        byte0_d = rx_byte;
        state_d = WAIT_B1;
      end else begin
        pkt_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= WAIT_B0;
      byte0_q      <= '0;
      byte1_q      <= '0;
      byte2_q      <= '0;
      gap_q        <= '0;
      cursor_x_q   <= X_HOME;
      cursor_y_q   <= Y_HOME;
      btn_left_q   <= 1'b0;
      btn_right_q  <= 1'b0;
      left_click_q <= 1'b0;
      pos_update_q <= 1'b0;
      pkt_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      byte2_q      <= byte2_d;
      gap_q        <= gap_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      btn_left_q   <= btn_left_d;
      btn_right_q  <= btn_right_d;
      left_click_q <= left_click_d;
      pos_update_q <= pos_update_d;
      pkt_error_q  <= pkt_error_d;
    end
  end

  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;
  assign btn_left   = btn_left_q;
  assign btn_right  = btn_right_q;
  assign left_click = left_click_q;
  assign pos_update = pos_update_q;
  assign pkt_error  = pkt_error_q;

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mouse_cursor_ctrl
// Scoreboard bench: the driver feeds bytes into a packet-level model that
// predicts each observable event (cycle, position, buttons, pulses); a
// monitor pops and compares whenever the DUT shows a pulse or button change.
// ---------------------------------------------------------------------------
module tb_mouse_cursor_ctrl;

  localparam int H = 640;
  localparam int V = 480;
  localparam int T = 50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [10:0] cursor_x, cursor_y;
  logic        btn_left, btn_right, left_click, pos_update, pkt_error;

  mouse_cursor_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYC(T)) dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .left_click (left_click),
    .pos_update (pos_update),
    .pkt_error  (pkt_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit bl;
    bit br;
    bit click;
    bit pu;
    bit err;
  } exp_t;

  exp_t sbq[$];

  // Packet-level reference state
  int         m_x, m_y, m_n;
  bit         m_bl, m_br;
  logic [7:0] m_b0, m_b1;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_x = H / 2; m_y = V / 2; m_n = 0; m_bl = 0; m_br = 0;
  endtask

  task automatic push_err(input int c);
    exp_t e;
    int   idx;
    if (sbq.size() > 0 && sbq[sbq.size()-1].cyc == c) begin
      idx = sbq.size() - 1;
      sbq[idx].err = 1'b1;
    end else begin
      e = '{cyc: c, x: m_x, y: m_y, bl: m_bl, br: m_br, click: 1'b0, pu: 1'b0, err: 1'b1};
      sbq.push_back(e);
    end
  endtask

  task automatic model_apply(input logic [7:0] b2, input int c);
    int   dx, dy, nx, ny;
    bit   nbl, nbr, click, err, pu, chg;
    exp_t e;
    dx    = int'(m_b1) - (m_b0[4] ? 256 : 0);
    dy    = int'(b2)   - (m_b0[5] ? 256 : 0);
    nbl   = m_b0[0];
    nbr   = m_b0[1];
    click = nbl && !m_bl;
    err   = m_b0[6] || m_b0[7];
    nx    = m_x;
    ny    = m_y;
    if (!err) begin
      nx = clampi(m_x + dx, H - 1);
      ny = clampi(m_y - dy, V - 1);
    end
    pu  = (nx != m_x) || (ny != m_y);
    chg = (nbl != m_bl) || (nbr != m_br);
    m_x = nx; m_y = ny; m_bl = nbl; m_br = nbr;
    if (err || pu || click || chg) begin
      e = '{cyc: c, x: m_x, y: m_y, bl: m_bl, br: m_br, click: click, pu: pu, err: err};
      sbq.push_back(e);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int p);
    case (m_n)
      0: begin
        if (b[3]) begin m_b0 = b; m_n = 1; end
        else push_err(p);
      end
      1: begin m_b1 = b; m_n = 2; end
      default: begin model_apply(b, p + 1); m_n = 0; end
    endcase
  endtask

  // Drive one byte at a negedge, then leave `gap` idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int p;
    rx_byte  = b;
    rx_valid = 1'b1;
    p = cyc + 1;
    model_byte(b, p);
    @(negedge clk);
    rx_valid = 1'b0;
    if (m_n != 0 && gap > T) begin
      m_n = 0;
      push_err(p + T + 1);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("check %s value=%0d", name, act);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d expected=0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  bit mon_en = 0;
  bit prev_bl = 0, prev_br = 0;

  task automatic do_reset();
    mon_en = 0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    mon_en = 1;
  endtask

  // Monitor: compares every observable event against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      prev_bl = btn_left;
      prev_br = btn_right;
    end else begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event actual_cyc=none expected_cyc=%0d now=%0d", sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      if (pkt_error || pos_update || left_click || btn_left != prev_bl || btn_right != prev_br) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d x=%0d y=%0d bl=%0d br=%0d click=%0d pu=%0d err=%0d expected=none",
                   cyc, cursor_x, cursor_y, btn_left, btn_right, left_click, pos_update, pkt_error);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.x != int'(cursor_x) || e.y != int'(cursor_y) || e.bl != btn_left ||
              e.br != btn_right || e.click != left_click || e.pu != pos_update || e.err != pkt_error) begin
            failures++;
            $display("FAIL event actual cyc=%0d x=%0d y=%0d bl=%0d br=%0d click=%0d pu=%0d err=%0d expected cyc=%0d x=%0d y=%0d bl=%0d br=%0d click=%0d pu=%0d err=%0d",
                     cyc, cursor_x, cursor_y, btn_left, btn_right, left_click, pos_update, pkt_error,
                     e.cyc, e.x, e.y, e.bl, e.br, e.click, e.pu, e.err);
          end else begin
            $display("txn cyc=%0d x=%0d y=%0d bl=%0d br=%0d click=%0d pu=%0d err=%0d ok",
                     cyc, cursor_x, cursor_y, btn_left, btn_right, left_click, pos_update, pkt_error);
          end
        end
      end
      prev_bl = btn_left;
      prev_br = btn_right;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_x", int'(cursor_x), 320);
    check("rst_y", int'(cursor_y), 240);
    check("rst_bits", int'({btn_left, btn_right, left_click, pos_update, pkt_error}), 0);

    // Basic packet
    send(8'h08, 1); send(8'h0A, 1); send(8'h05, 2);
    drain();
    check("p1_x", int'(cursor_x), 330);
    check("p1_y", int'(cursor_y), 235);

    // Drive to (0,0), then negative deltas clamp X at 0 and push Y down
    send(8'h18, 0); send(8'h00, 0); send(8'hFF, 2);
    send(8'h18, 0); send(8'h00, 0); send(8'hFF, 2);
    drain();
    check("corner_x", int'(cursor_x), 0);
    check("corner_y", int'(cursor_y), 0);
    send(8'h38, 1); send(8'hF0, 1); send(8'hF0, 2);
    drain();
    check("neg_x", int'(cursor_x), 0);
    check("neg_y", int'(cursor_y), 16);

    // Same left-button packet twice: one click, no movement
    send(8'h09, 1); send(8'h00, 1); send(8'h00, 3);
    send(8'h09, 1); send(8'h00, 1); send(8'h00, 3);
    drain();
    check("click_btn_left", int'(btn_left), 1);

    // Resync byte, then a good packet
    do_reset();
    send(8'h02, 2); send(8'h08, 1); send(8'h01, 1); send(8'h00, 2);
    drain();
    check("resync_x", int'(cursor_x), 321);

    // Inter-byte timeout discards the partial packet
    do_reset();
    send(8'h08, 1); send(8'h05, T + 1);
    send(8'h08, 1); send(8'h01, 1); send(8'h00, 2);
    drain();
    check("timeout_x", int'(cursor_x), 321);

    // Overflow: movement ignored, buttons still follow byte0
    send(8'h4B, 1); send(8'hFF, 1); send(8'h00, 2);
    drain();
    check("ovf_x", int'(cursor_x), 321);
    check("ovf_y", int'(cursor_y), 240);
    check("ovf_btn_right", int'(btn_right), 1);

    // Reset mid-packet: next byte is a fresh byte0
    send(8'h08, 0); send(8'h05, 1);
    do_reset();
    send(8'h08, 0); send(8'h01, 0); send(8'h00, 3);
    drain();
    check("midrst_x", int'(cursor_x), 321);

    // Bytes arriving in the APPLY cycle: a bad one, then a good byte0
    send(8'h08, 0); send(8'h10, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h08, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'h09, 0); send(8'h02, 0); send(8'h00, 3);
    drain();
    check("apply_overlap_x", int'(cursor_x), 340);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end else begin
        b0 = 8'($urandom_range(0, 255));
        b0[3] = 1'b1;
        if ($urandom_range(0, 6) != 0) b0[7:6] = 2'b00;
        send(b0, $urandom_range(0, 3));
        send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
        send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end
    end
    while (m_n != 0) send(8'h00, 1);
    drain();
    check("rand_final_x", int'(cursor_x), m_x);
    check("rand_final_y", int'(cursor_y), m_y);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_ctrl.md
MOUSE_CURSOR_CTRL -- requirements
Module: mouse_cursor_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible height in pixels.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, maximum inter-byte gap in clocks (1 ms at 50 MHz).
REQ-004 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port rx_byte  input  8  PS/2 mouse byte from the receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe; rx_byte is valid in that cycle.
REQ-008 SHALL have port cursor_x  output  11  cursor centre column, registered.
REQ-009 SHALL have port cursor_y  output  11  cursor centre row, registered.
REQ-010 SHALL have port btn_left  output  1  current left-button level.
REQ-011 SHALL have port btn_right  output  1  current right-button level.
REQ-012 SHALL have port left_click  output  1  one-cycle pulse on left-button press.
REQ-013 SHALL have port pos_update  output  1  one-cycle pulse when cursor_x/cursor_y change value.
REQ-014 SHALL have port pkt_error  output  1  one-cycle pulse on discarded byte or packet.

Function
REQ-015 SHALL implement FSM states WAIT_B0, WAIT_B1, WAIT_B2, APPLY.
REQ-016 WAIT_B0 + rx_valid: bit3 = 1 -> latch byte0, go to WAIT_B1; bit3 = 0 -> stay in WAIT_B0, pulse pkt_error (resync).
REQ-017 WAIT_B1 + rx_valid -> latch byte1, go to WAIT_B2; WAIT_B2 + rx_valid -> latch byte2, go to APPLY.
REQ-018 APPLY SHALL last exactly one cycle, then return to WAIT_B0; an rx_valid arriving in APPLY SHALL be processed as a WAIT_B0 byte.
REQ-019 dx SHALL be 9-bit two's complement {byte0[4], byte1}; dy SHALL be {byte0[5], byte2}.
REQ-020 In APPLY: new_x = cursor_x + dx; new_y = cursor_y - dy (PS/2 +Y is up, screen +Y is down).
REQ-021 Arithmetic SHALL use at least 13-bit signed intermediates; results clamp to [0, H_ACTIVE-1] and [0, V_ACTIVE-1].
REQ-022 If byte0[6] (X overflow) or byte0[7] (Y overflow) is set, the movement SHALL be ignored, buttons still updated, and pkt_error pulsed.
REQ-023 Outputs updated in APPLY SHALL be visible the cycle after APPLY (3rd byte strobe -> outputs valid 2 cycles later).
REQ-024 pos_update SHALL pulse in that same cycle only when the clamped position differs from the previous one.
REQ-025 btn_left = byte0[0], btn_right = byte0[1]; left_click SHALL pulse only on a 0->1 transition of btn_left.
REQ-026 A gap counter SHALL reset on every rx_valid; in WAIT_B1/WAIT_B2, reaching TIMEOUT_CYC SHALL return the FSM to WAIT_B0 and pulse pkt_error.
REQ-027 Gap counter SHALL saturate, never wrap; in WAIT_B0 a timeout SHALL have no effect.

Reset
REQ-028 With reset = 0 on a clock edge: FSM -> WAIT_B0, cursor_x = H_ACTIVE/2 (320), cursor_y = V_ACTIVE/2 (240), all 1-bit outputs 0, gap counter 0.
REQ-029 Reset mid-packet SHALL discard the partial packet; the first byte after reset is treated as byte0.

Structure
REQ-030 FSM state encoding, default screen dimensions and TIMEOUT_CYC SHALL reside in a shared package used by the display blocks.
REQ-031 Delta decode and clamp SHALL be a sub-module named cursor_clamp (combinational: position, delta, limit -> clamped position).

Verification
REQ-032 After reset, packet 08,0A,05 -> cursor_x = 330, cursor_y = 235, pos_update pulses once.
REQ-033 From (0,0): packet 38,F0,F0 (dx = -16, dy = -16) -> cursor_x = 0, cursor_y = 16.
REQ-034 Packet 09,00,00 twice -> left_click pulses only after the first packet, btn_left = 1, pos_update never pulses.
REQ-035 Byte 02 while in WAIT_B0 -> pkt_error pulse; following 08,01,00 accepted -> cursor_x = 321.
REQ-036 Bytes 08,05, then 50001 idle cycles, then 08,01,00 -> pkt_error pulse at timeout, cursor_x = 321.
REQ-037 Packet 48,FF,00 (X overflow) -> position unchanged, pkt_error pulses, buttons updated.
